// File: rtl/dino_timer_pkg.sv
// Shared definitions for the dino game timers: mode encodings and the
// default timer width used by the obstacle and score logic.
package dino_timer_pkg;

    // Timer mode encodings (sampled on every tick).
    localparam logic MODE_ONESHOT  = 1'b0;
    localparam logic MODE_PERIODIC = 1'b1;

    // Default counter width shared with the obstacle/score logic.
    localparam int TIMER_WIDTH = 9;

endpackage : dino_timer_pkg

// File: rtl/tick_prescaler.sv
// Clock prescaler: emits a one-cycle tick once every PRESCALE enabled cycles.
// With PRESCALE == 1 the counter is pinned at 0 and tick simply follows enable.
module tick_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = $clog2(PRESCALE) + 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] cnt;

    // Count enabled cycles, wrap at PRESCALE-1; clear (a load) restarts the phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign tick = enable && (cnt == LAST);

endmodule : tick_prescaler

// File: rtl/obstacle_down_timer.sv
// Loadable down-timer pacing obstacle spawns. Decrements by a variable step
// on every prescaled tick, saturates at 0 with a one-cycle tc_pulse, and
// either stops (one-shot) or reloads from reload_reg (periodic).
//
// Load handshake: a load transfers on a rising clock edge where
// load_valid && load_ready are both high. load_ready is low only on the
// first edge after reset is released; load_valid may be held or dropped
// freely and carries no commitment while load_ready is low.
module obstacle_down_timer
    import dino_timer_pkg::*;
#(
    parameter int               WIDTH          = TIMER_WIDTH,
    parameter int               STEP_W         = 4,
    parameter int               PRESCALE       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE    = WIDTH'(2**WIDTH - 1),
    parameter bit               START_ON_RESET = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              mode,
    input  logic [STEP_W-1:0] step,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [WIDTH-1:0]  load_value,
    output logic [WIDTH-1:0]  count,
    output logic              zero,
    output logic              tc_pulse,
    output logic              running
);

    // Comparison width wide enough for both count and step.
    localparam int CMP_W = (WIDTH > STEP_W) ? WIDTH : STEP_W;

    logic             load_fire;
    logic             tick;
    logic [WIDTH-1:0] reload_reg;
    logic [CMP_W-1:0] count_x;
    logic [CMP_W-1:0] step_x;

    assign load_fire = load_valid && load_ready;
    assign count_x   = CMP_W'(count);
    assign step_x    = CMP_W'(step);
    assign zero      = (count == '0);

    // A load restarts the prescaler phase so the first tick is a full period away.
    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clock  (clock),
        .reset  (reset),
        .enable (enable),
        .clear  (load_fire),
        .tick   (tick)
    );

    // load_ready is a registered copy of ~reset: it masks loads on the first edge out of reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_ready <= 1'b0;
        end else begin
            load_ready <= 1'b1;
        end
    end

    // Count, reload and running update; a load wins over a coincident tick.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count      <= RESET_VALUE;
            reload_reg <= RESET_VALUE;
            running    <= START_ON_RESET;
            tc_pulse   <= 1'b0;
        end else begin
            tc_pulse <= 1'b0;
            if (load_fire) begin
                reload_reg <= load_value;
                count      <= load_value;
                running    <= (load_value != '0);
            end else if (tick && running && (step != '0)) begin
                // step == 0 is a pause: nothing moves, not even the reload from 0.
                if (count_x > step_x) begin
                    count <= WIDTH'(count_x - step_x);
                end else if (count != '0) begin
                    // Saturate at 0 rather than wrapping; one-shot stops on this same edge.
                    count    <= '0;
                    tc_pulse <= 1'b1;
                    if (mode == MODE_ONESHOT) begin
                        running <= 1'b0;
                    end
                end else if (mode == MODE_PERIODIC) begin
                    count <= reload_reg;
                    if (reload_reg == '0) begin
                        running <= 1'b0;
                    end
                end else begin
                    running <= 1'b0;
                end
            end
        end
    end

endmodule : obstacle_down_timer
